addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 119 +++++++++++
 tb/tb_addsub_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Segmented-carry pipelined adder/subtractor: one carry-chain slice per stage,
// whole-pipeline stall on output back-pressure, flags registered with the result.
module addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter int SEGMENTS = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SW = WIDTH / SEGMENTS;

  // Stage k holds an operation whose slices below k are already summed.
  logic             r_vld [SEGMENTS];
  logic [WIDTH-1:0] r_a   [SEGMENTS];
  logic [WIDTH-1:0] r_bx  [SEGMENTS];
  logic [WIDTH-1:0] r_sum [SEGMENTS];
  logic             r_c   [SEGMENTS];
  logic             r_sub [SEGMENTS];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  logic [SW:0]      w_seg  [SEGMENTS];
  logic [WIDTH-1:0] w_nsum [SEGMENTS];
  logic             w_advance;
  logic [WIDTH-1:0] w_fin;
  logic             w_fin_c;
  logic             w_ovf;

  assign w_advance = ~(r_out_valid & ~out_ready);
  assign in_ready  = w_advance;

  always_comb begin
    for (int k = 0; k < SEGMENTS; k++) begin
      w_seg[k]  = {1'b0, r_a[k][k*SW +: SW]} + {1'b0, r_bx[k][k*SW +: SW]}
                + {{SW{1'b0}}, r_c[k]};
      w_nsum[k] = r_sum[k];
      w_nsum[k][k*SW +: SW] = w_seg[k][SW-1:0];
    end
  end

  assign w_fin   = w_nsum[SEGMENTS-1];
  assign w_fin_c = w_seg[SEGMENTS-1][SW];
  // B is already inverted in subtract mode, so equal operand MSBs mean same-sign add.
  assign w_ovf   = (r_a[SEGMENTS-1][WIDTH-1] == r_bx[SEGMENTS-1][WIDTH-1])
                && (w_fin[WIDTH-1] != r_a[SEGMENTS-1][WIDTH-1]);

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_bx[k]  <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      r_a[0]   <= A;
      r_bx[0]  <= B ^ {WIDTH{sub}};
      r_sum[0] <= '0;
      r_c[0]   <= sub;
      r_sub[0] <= sub;
      for (int k = 1; k < SEGMENTS; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_bx[k]  <= r_bx[k-1];
        r_sum[k] <= w_nsum[k-1];
        r_c[k]   <= w_seg[k-1][SW];
        r_sub[k] <= r_sub[k-1];
      end
      r_out_valid <= r_vld[SEGMENTS-1];
      if (r_vld[SEGMENTS-1]) begin
        r_result   <= w_fin;
        r_cout     <= w_fin_c;
        r_borrow   <= r_sub[SEGMENTS-1] & ~w_fin_c;
        r_overflow <= w_ovf;
        r_zero     <= (w_fin == '0);
        r_negative <= w_fin[WIDTH-1];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign negative  = r_negative;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=32, SEGMENTS=4): directed flag cases, clear
// behaviour, and a randomized back-pressure run against an arithmetic model.
module tb_addsub_pipe;

  localparam int W   = 32;
  localparam int SEG = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          borrow;
  logic          overflow;
  logic          zero;
  logic          negative;

  int tests = 0;
  int fails = 0;

  addsub_pipe #(.WIDTH(W), .SEGMENTS(SEG)) dut (
    .clock(clock), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .borrow(borrow),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clock = ~clock;

  // {result, cout, borrow, overflow, zero, negative}
  function automatic logic [W+4:0] outvec();
    return {result, cout, borrow, overflow, zero, negative};
  endfunction

  function automatic logic [W+4:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, br, ov;
    longint       sa, sb, st;
    wide = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r    = wide[W-1:0];
    c    = s ? (a >= b) : wide[W];
    br   = s && (a < b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    st   = s ? (sa - sb) : (sa + sb);
    ov   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return {r, c, br, ov, (r == '0), r[W-1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high and verify exact latency and outputs.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W+4:0] exp);
    @(negedge clock);
    A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (int k = 1; k < SEG; k++) begin
      @(negedge clock);
      #1;
      check({tag, "_early"}, 64'(out_valid), 64'd0);
    end
    @(negedge clock);
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(outvec()), 64'(exp));
    @(negedge clock);
  endtask

  logic [W+4:0] q[$];
  logic [W+4:0] held, expv;
  logic         acc, stalled;
  int           sent, got, cyc;

  initial begin
    clear = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(outvec()), 64'd0);
    clear = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    directed("sub_5_3",      32'd5,          32'd3, 1'b1, {32'd2,          5'b10000});
    directed("sub_0_1",      32'd0,          32'd1, 1'b1, {32'hFFFF_FFFF,  5'b01001});
    directed("sub_min_1",    32'h8000_0000,  32'd1, 1'b1, {32'h7FFF_FFFF,  5'b10100});
    directed("add_max_1",    32'hFFFF_FFFF,  32'd1, 1'b0, {32'd0,          5'b10010});
    directed("add_smax_1",   32'h7FFF_FFFF,  32'd1, 1'b0, {32'h8000_0000,  5'b00101});

    // Randomized back-to-back traffic with pseudo-random back-pressure.
    sent = 0; got = 0; cyc = 0;
    @(negedge clock);
    in_valid = 1'b1; A = $urandom; B = $urandom; sub = 1'($urandom);
    out_ready = ($urandom % 3) != 0;
    while (got < 16 && cyc < 400) begin
      #1;
      check("rand_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(A, B, sub));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 64'd1, 64'd0);
        end else begin
          expv = q.pop_front();
          check("rand_result", 64'(outvec()), 64'(expv));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = outvec();
      @(posedge clock);
      @(negedge clock);
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(outvec()), 64'(held));
      end
      if (acc) begin
        sent++;
        if (sent < 16) begin
          A = $urandom; B = $urandom; sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom % 3) != 0;
      cyc++;
    end
    check("rand_count", 64'(got), 64'd16);
    check("rand_queue_empty", 64'(q.size()), 64'd0);

    // Three ops in flight, then a one-cycle clear.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid = 1'b1; A = $urandom; B = $urandom; sub = 1'(i);
    end
    @(negedge clock);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clear_in_ready", 64'(in_ready), 64'd1);
    check("clear_outputs", 64'(outvec()), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("clear_no_out", 64'(out_valid), 64'd0);
      @(negedge clock);
      #1;
    end
    A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    directed("after_clear", A, B, 1'b1, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
